fifo_rd_packer: RTL



---
 rtl/fifo_rd_packer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fifo_rd_packer.sv
// Read-side packer for async_fifo: pops narrow FIFO entries and packs PACK_RATIO of them
// LSB-first into one wide word on a valid/ready port; flush emits a partial word with its beat count.
module fifo_rd_packer #(
    parameter int  DATA_WIDTH = 4,
    parameter int  PACK_RATIO = 4,
    localparam int OUT_WIDTH  = DATA_WIDTH * PACK_RATIO,
    localparam int CNT_WIDTH  = $clog2(PACK_RATIO + 1)
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [CNT_WIDTH-1:0]  out_beats
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] FULL_CNT   = CNT_WIDTH'(PACK_RATIO);
    localparam logic [CNT_WIDTH:0]   FULL_LEVEL = (CNT_WIDTH + 1)'(PACK_RATIO);

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_WIDTH-1:0]   beat_cnt;
    logic [CNT_WIDTH-1:0]   beat_cnt_nxt;
    logic [CNT_WIDTH-1:0]   cap_cnt;
    logic [CNT_WIDTH:0]     fill_level;
    logic                   pend;
    logic                   flush_pend;
    logic                   flush_pend_nxt;
    logic [CNT_WIDTH-1:0]   out_beats_nxt;
    logic                   clear_word;
    logic [OUT_WIDTH-1:0]   data;

    // Beats held plus the read still in flight; never request more than one word's worth.
    assign fill_level = {1'b0, beat_cnt} + {{CNT_WIDTH{1'b0}}, pend};
    assign cap_cnt    = beat_cnt + {{(CNT_WIDTH-1){1'b0}}, pend};
    assign fifo_rd_en = !rd_rst && (state == ST_FILL) && !fifo_empty && (fill_level < FULL_LEVEL);

    assign out_valid  = (state == ST_OUT);
    assign out_data   = data;

    // Next-state and control decode.
    always_comb begin
        state_nxt      = state;
        beat_cnt_nxt   = cap_cnt;
        flush_pend_nxt = flush_pend;
        out_beats_nxt  = out_beats;
        clear_word     = 1'b0;
        case (state)
            ST_FILL: begin
                if (pend && (cap_cnt == FULL_CNT)) begin
                    // Word completes now, so a coincident flush has nothing left to push out.
                    state_nxt      = ST_OUT;
                    out_beats_nxt  = FULL_CNT;
                    flush_pend_nxt = 1'b0;
                end else if (flush || flush_pend) begin
                    state_nxt      = ST_DRAIN;
                    flush_pend_nxt = 1'b0;
                end else begin
                    state_nxt      = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (flush) begin
                    flush_pend_nxt = 1'b1;
                end else begin
                    flush_pend_nxt = flush_pend;
                end
                // No reads are issued here, so after this cycle's capture nothing is in flight.
                if (cap_cnt != {CNT_WIDTH{1'b0}}) begin
                    state_nxt     = ST_OUT;
                    out_beats_nxt = cap_cnt;
                end else begin
                    state_nxt     = ST_FILL;
                end
            end
            ST_OUT: begin
                if (flush) begin
                    flush_pend_nxt = 1'b1;
                end else begin
                    flush_pend_nxt = flush_pend;
                end
                if (out_ready) begin
                    state_nxt     = ST_FILL;
                    beat_cnt_nxt  = {CNT_WIDTH{1'b0}};
                    out_beats_nxt = {CNT_WIDTH{1'b0}};
                    clear_word    = 1'b1;
                end else begin
                    state_nxt     = ST_OUT;
                end
            end
            default: begin
                state_nxt      = ST_FILL;
                beat_cnt_nxt   = {CNT_WIDTH{1'b0}};
                flush_pend_nxt = 1'b0;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state      <= ST_FILL;
            beat_cnt   <= {CNT_WIDTH{1'b0}};
            pend       <= 1'b0;
            flush_pend <= 1'b0;
            out_beats  <= {CNT_WIDTH{1'b0}};
        end else begin
            state      <= state_nxt;
            beat_cnt   <= beat_cnt_nxt;
            pend       <= fifo_rd_en;
            flush_pend <= flush_pend_nxt;
            out_beats  <= out_beats_nxt;
        end
    end

    // Slot register: returning read data lands in slot beat_cnt; cleared after each handshake.
    always_ff @(posedge rd_clk) begin
        if (rd_rst || clear_word) begin
            data <= {OUT_WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < PACK_RATIO; i++) begin
                if (pend && (beat_cnt == CNT_WIDTH'(i))) begin
                    data[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_rd_data;
                end
            end
        end
    end

endmodule
